// File: rtl/riscv_arb_pkg.sv
// Shared types and constants for the four-requester bus arbiter.
package riscv_arb_pkg;

  localparam int NREQ = 4;

  localparam logic [1:0] IFU  = 2'd0;
  localparam logic [1:0] LSU  = 2'd1;
  localparam logic [1:0] PTW  = 2'd2;
  localparam logic [1:0] UART = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/riscv_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, modulo 4.
module riscv_rr_picker
  import riscv_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      ptr_i,
  output logic            found_o,
  output logic [1:0]      idx_o,
  output logic [NREQ-1:0] onehot_o
);

  always_comb begin
    logic [1:0] cand;
    cand    = '0;
    found_o = 1'b0;
    idx_o   = '0;
    // Scan farthest-first so the candidate nearest ptr is written last and wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr_i + 2'(i);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
    onehot_o = found_o ? (4'b0001 << idx_o) : '0;
  end

endmodule

// File: rtl/riscv_bus_arbiter4.sv
// Round-robin owner of a shared bus port for four requesters; drives mux select and handshake.
// Optional WAIT timeout is compiled in with RISCV_ARB_TIMEOUT_EN.
module riscv_bus_arbiter4
  import riscv_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            i_riscv_clk,
  input  logic            i_riscv_rst,
  input  logic [NREQ-1:0] i_riscv_arb_req,
  output logic [NREQ-1:0] o_riscv_arb_gnt,
  output logic [1:0]      o_riscv_arb_sel,
  output logic            o_riscv_arb_bus_valid,
  input  logic            i_riscv_arb_bus_ready,
  input  logic            i_riscv_arb_bus_done,
  output logic [NREQ-1:0] o_riscv_arb_done,
  output logic            o_riscv_arb_busy,
  output logic            o_riscv_arb_timeout
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      ptr_q, ptr_d;

  logic            pick_found;
  logic [1:0]      pick_idx;
  logic [NREQ-1:0] pick_onehot;
  logic            done_acc;
  logic            to_expire;

  riscv_rr_picker u_picker (
    .req_i    (i_riscv_arb_req),
    .ptr_i    (ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  // Completion is only accepted while a command is in flight; stray done in IDLE is dropped.
  assign done_acc = i_riscv_arb_bus_done &&
                    ((state_q == ISSUE && i_riscv_arb_bus_ready) || state_q == WAIT);

`ifdef RISCV_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;

  // Counter reads k during the k-th WAIT cycle, so expiry lands on cycle TIMEOUT_CYCLES.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE && i_riscv_arb_bus_ready && !i_riscv_arb_bus_done) begin
      cnt_d = 16'd1;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_riscv_clk) begin
    if (i_riscv_rst) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end

  assign to_expire = (state_q == WAIT) && !i_riscv_arb_bus_done && (cnt_q == TO_LIMIT);
`else
  assign to_expire = 1'b0;
`endif

  always_ff @(posedge i_riscv_clk) begin
    if (i_riscv_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = ISSUE;
          gnt_d   = pick_onehot;
          sel_d   = pick_idx;
        end
      end
      ISSUE: begin
        if (i_riscv_arb_bus_ready) state_d = i_riscv_arb_bus_done ? IDLE : WAIT;
      end
      WAIT: begin
        if (i_riscv_arb_bus_done || to_expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The finishing owner drops to lowest priority; sel is kept for the idle period.
    if (done_acc || to_expire) begin
      gnt_d = '0;
      ptr_d = sel_q + 2'd1;
    end
  end

  always_comb begin
    o_riscv_arb_gnt       = gnt_q;
    o_riscv_arb_sel       = sel_q;
    o_riscv_arb_bus_valid = (state_q == ISSUE);
    o_riscv_arb_busy      = (state_q != IDLE);
    o_riscv_arb_done      = (done_acc && !i_riscv_rst) ? gnt_q : '0;
    o_riscv_arb_timeout   = to_expire && !i_riscv_rst;
  end

endmodule

// File: tb/tb_riscv_bus_arbiter4.sv
// Directed vector bench for riscv_bus_arbiter4; timeout sequences run when RISCV_ARB_TIMEOUT_EN is defined.
module tb_riscv_bus_arbiter4;
  import riscv_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rdy, dn;
  logic [3:0] gnt, done_o;
  logic [1:0] sel;
  logic       valid, busy, tmo;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic       dn;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] done;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  riscv_bus_arbiter4 #(.TIMEOUT_CYCLES(4)) dut (
    .i_riscv_clk           (clk),
    .i_riscv_rst           (rst),
    .i_riscv_arb_req       (req),
    .o_riscv_arb_gnt       (gnt),
    .o_riscv_arb_sel       (sel),
    .o_riscv_arb_bus_valid (valid),
    .i_riscv_arb_bus_ready (rdy),
    .i_riscv_arb_bus_done  (dn),
    .o_riscv_arb_done      (done_o),
    .o_riscv_arb_busy      (busy),
    .o_riscv_arb_timeout   (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic [3:0] q, input logic rd, input logic d);
    @(negedge clk);
    rst = r; req = q; rdy = rd; dn = d;
    #1;
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic rd, input logic d,
                     input logic [3:0] g, input logic [1:0] s, input logic v,
                     input logic [3:0] dno, input logic b);
    vec_t t;
    t.rst = r; t.req = q; t.rdy = rd; t.dn = d;
    t.gnt = g; t.sel = s; t.valid = v; t.done = dno; t.busy = b;
    vecs.push_back(t);
  endtask

  initial begin
    rst = 1'b1; req = '0; rdy = 1'b0; dn = 1'b0;
    //   rst req     rdy dn  gnt     sel   val done    busy
    add(0, 4'b0100, 1, 1, 4'b0000, 2'd0, 0, 4'b0000, 0); // reset state, stray done/ready ignored
    add(0, 4'b0100, 1, 0, 4'b0100, PTW,  1, 4'b0000, 1);
    add(0, 4'b0000, 0, 0, 4'b0100, PTW,  0, 4'b0000, 1); // req dropped in WAIT
    add(0, 4'b0000, 0, 1, 4'b0100, PTW,  0, 4'b0100, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, PTW,  0, 4'b0000, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, PTW,  0, 4'b0000, 0);
    add(0, 4'b1111, 0, 0, 4'b0000, IFU,  0, 4'b0000, 0);
    add(0, 4'b1111, 1, 1, 4'b0001, IFU,  1, 4'b0001, 1);
    add(0, 4'b1111, 1, 1, 4'b0000, IFU,  0, 4'b0000, 0);
    add(0, 4'b1111, 1, 1, 4'b0010, LSU,  1, 4'b0010, 1);
    add(0, 4'b1111, 1, 1, 4'b0000, LSU,  0, 4'b0000, 0);
    add(0, 4'b1111, 1, 1, 4'b0100, PTW,  1, 4'b0100, 1);
    add(0, 4'b1111, 1, 1, 4'b0000, PTW,  0, 4'b0000, 0);
    add(0, 4'b1111, 1, 1, 4'b1000, UART, 1, 4'b1000, 1);
    add(0, 4'b1111, 1, 1, 4'b0000, UART, 0, 4'b0000, 0);
    add(0, 4'b1111, 1, 1, 4'b0001, IFU,  1, 4'b0001, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, IFU,  0, 4'b0000, 0);
    add(0, 4'b0011, 0, 0, 4'b0000, IFU,  0, 4'b0000, 0);
    add(0, 4'b0011, 0, 1, 4'b0010, LSU,  1, 4'b0000, 1); // done without ready ignored
    add(0, 4'b0011, 1, 0, 4'b0010, LSU,  1, 4'b0000, 1);
    add(0, 4'b0011, 0, 1, 4'b0010, LSU,  0, 4'b0010, 1);
    add(0, 4'b0011, 0, 0, 4'b0000, LSU,  0, 4'b0000, 0);
    add(0, 4'b0011, 1, 1, 4'b0001, IFU,  1, 4'b0001, 1); // ptr=2 wraps to requester 0
    add(0, 4'b0000, 0, 0, 4'b0000, IFU,  0, 4'b0000, 0);

    drive(1, 4'b0000, 0, 0);
    drive(1, 4'b0000, 0, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].rdy, vecs[i].dn);
      $display("[TB] vec %0d rst=%0b req=%b rdy=%0b dn=%0b -> gnt=%b sel=%0d val=%0b done=%b busy=%0b",
               i, rst, req, rdy, dn, gnt, sel, valid, done_o, busy);
      chk($sformatf("vec%0d_gnt", i),   32'(gnt),    32'(vecs[i].gnt));
      chk($sformatf("vec%0d_sel", i),   32'(sel),    32'(vecs[i].sel));
      chk($sformatf("vec%0d_valid", i), 32'(valid),  32'(vecs[i].valid));
      chk($sformatf("vec%0d_done", i),  32'(done_o), 32'(vecs[i].done));
      chk($sformatf("vec%0d_busy", i),  32'(busy),   32'(vecs[i].busy));
      chk($sformatf("vec%0d_tmo", i),   32'(tmo),    32'(0));
    end

    // ISSUE backpressure: five cycles without ready, stray done on the third.
    drive(1, 4'b0000, 0, 0);
    drive(0, 4'b1000, 0, 0);
    for (int c = 0; c < 5; c++) begin
      drive(0, 4'b0000, 0, (c == 2));
      $display("[TB] backpressure c=%0d gnt=%b sel=%0d val=%0b done=%b", c, gnt, sel, valid, done_o);
      chk("bp_gnt", 32'(gnt), 32'(4'b1000));
      chk("bp_sel", 32'(sel), 32'(UART));
      chk("bp_valid", 32'(valid), 32'(1));
      chk("bp_done", 32'(done_o), 32'(0));
    end
    drive(0, 4'b0000, 1, 1);
    $display("[TB] backpressure release done=%b", done_o);
    chk("bp_release_done", 32'(done_o), 32'(4'b1000));
    drive(0, 4'b0000, 0, 0);
    chk("bp_idle_busy", 32'(busy), 32'(0));

    // Reset while in WAIT owned by requester 1.
    drive(1, 4'b0000, 0, 0);
    drive(0, 4'b0010, 0, 0);
    drive(0, 4'b0010, 1, 0);
    chk("rw_issue_gnt", 32'(gnt), 32'(4'b0010));
    drive(0, 4'b0000, 0, 0);
    chk("rw_wait_busy", 32'(busy), 32'(1));
    drive(1, 4'b0000, 0, 0);
    drive(0, 4'b0000, 0, 1);
    $display("[TB] after reset-in-wait gnt=%b val=%0b busy=%0b done=%b", gnt, valid, busy, done_o);
    chk("rw_gnt", 32'(gnt), 32'(0));
    chk("rw_valid", 32'(valid), 32'(0));
    chk("rw_busy", 32'(busy), 32'(0));
    chk("rw_late_done", 32'(done_o), 32'(0));
    drive(0, 4'b1111, 0, 1);
    chk("rw_idle_done", 32'(done_o), 32'(0));
    drive(0, 4'b1111, 0, 0);
    $display("[TB] post-reset arbitration gnt=%b", gnt);
    chk("rw_ptr_reset_gnt", 32'(gnt), 32'(4'b0001));

`ifdef RISCV_ARB_TIMEOUT_EN
    // Done never arrives: abort on the 4th WAIT cycle.
    drive(1, 4'b0000, 0, 0);
    drive(0, 4'b0001, 0, 0);
    drive(0, 4'b0000, 1, 0);
    for (int w = 1; w <= 4; w++) begin
      drive(0, 4'b0000, 0, 0);
      $display("[TB] timeout wait=%0d tmo=%0b done=%b busy=%0b", w, tmo, done_o, busy);
      chk("to_pulse", 32'(tmo), 32'(w == 4));
      chk("to_done", 32'(done_o), 32'(0));
    end
    drive(0, 4'b1111, 0, 0);
    chk("to_idle_busy", 32'(busy), 32'(0));
    chk("to_idle_tmo", 32'(tmo), 32'(0));
    drive(0, 4'b1111, 1, 0);
    chk("to_ptr_gnt", 32'(gnt), 32'(4'b0010));
    // Done coinciding with expiry wins.
    for (int w = 1; w <= 4; w++) begin
      drive(0, 4'b0000, 0, (w == 4));
      chk("to_race_tmo", 32'(tmo), 32'(0));
    end
    $display("[TB] timeout race done=%b tmo=%0b", done_o, tmo);
    chk("to_race_done", 32'(done_o), 32'(4'b0010));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_bus_arbiter4.md
# riscv_bus_arbiter4

Round-robin arbiter that shares one memory/bus port between four requesters: instruction fetch, data access, page-table walker and UART TX DMA. It owns the 2-bit select of the shared 4:1 payload mux (address, write data, size) placed in front of the port. It also sequences the port handshake and returns a one-hot completion pulse to the winning requester. The block is control-only; no payload passes through it.

## Interface
- TIMEOUT_CYCLES, 255: maximum WAIT-state cycles before abort. Used only when the timeout feature is compiled in. Legal range is 1..65535.
- i_riscv_clk  in  1  core clock, rising edge
- i_riscv_rst  in  1  reset, synchronous, active-high
- i_riscv_arb_req  in  4  per-requester request, level, bit k = requester k
- o_riscv_arb_gnt  out  4  registered one-hot grant, 0 when idle
- o_riscv_arb_sel  out  2  registered binary index of granted requester, drives shared mux select
- o_riscv_arb_bus_valid  out  1  command valid to bus port
- i_riscv_arb_bus_ready  in  1  bus accepts command
- i_riscv_arb_bus_done  in  1  bus transaction complete (response valid)
- o_riscv_arb_done  out  4  one-hot completion pulse to owner
- o_riscv_arb_busy  out  1  high in ISSUE or WAIT
- o_riscv_arb_timeout  out  1  one-cycle abort pulse, constant 0 when the feature is not compiled in

## Operation
- States:
  - IDLE: gnt=0, valid=0.
  - ISSUE: valid=1.
  - WAIT: valid=0, awaiting done.
- IDLE:
  - If req≠0, pick the winner by round-robin starting at ptr, searching ptr, ptr+1, … modulo 4.
  - Register gnt and sel, then go to ISSUE.
  - If req=0, stay in IDLE.
- ISSUE:
  - Hold valid, gnt and sel stable until ready.
  - ready & done in the same cycle: pulse done, go to IDLE.
  - ready only: go to WAIT.
  - done without ready is ignored.
- WAIT: on done, pulse done, go to IDLE.
- o_riscv_arb_done = gnt when done is accepted, otherwise 0. It is combinational from registered gnt and i_riscv_arb_bus_done.
- On every completion or abort, ptr ← sel+1, wrapping 3→0. The last winner therefore becomes lowest priority.
- A req deassert mid-transaction is ignored; the transaction completes normally.
- A req still high after its done pulse is a new request. It re-arbitrates at lowest priority.
- i_riscv_arb_bus_done in IDLE is ignored; no pulse is produced.
- gnt and sel change only on the IDLE→ISSUE transition and on return to IDLE. sel holds its last value while idle, and gnt is 0 while idle.

## Timing
- Reset values:
  - state IDLE
  - gnt 0, sel 0, ptr 0 (requester 0 highest priority)
  - valid 0, busy 0, done 0, timeout 0
  - timeout counter 0
- Reset asserted mid-transaction aborts immediately: no done pulse, no timeout pulse.
- Latency:
  - req seen in IDLE at cycle n → gnt, sel and valid high at n+1.
  - ready at cycle n+1 with done at n+1 → done pulse at n+1, IDLE at n+2.
- Back-to-back transactions: done at cycle m → IDLE at m+1 (arbitrate) → next valid at m+2. The minimum gap is one idle cycle.
- valid is never high in WAIT or IDLE. At most one transaction is outstanding.

## Configuration
- RISCV_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter equals TIMEOUT_CYCLES and done is low, the block pulses o_riscv_arb_timeout for one cycle and returns to IDLE with no done pulse.
  - ptr advances as on completion.
  - done and timeout in the same cycle: done wins, no timeout pulse.
- RISCV_ARB_TIMEOUT_EN undefined:
  - No counter is built.
  - WAIT exits only on done.
  - o_riscv_arb_timeout is tied to 0.

## Structure
- Package riscv_arb_pkg:
  - NREQ=4.
  - Requester index localparams: IFU=0, LSU=1, PTW=2, UART=3.
  - Typedef enum logic [1:0] arb_state_t {IDLE, ISSUE, WAIT}.
- Sub-module riscv_rr_picker, purely combinational:
  - Inputs: 4-bit req, 2-bit ptr.
  - Outputs: found, 2-bit idx, 4-bit one-hot.
  - Instantiated once in the IDLE decision path.

## Test plan
- Single request: reset, req=0100 → cycle+1 gnt=0100, sel=2, valid=1. ready at +1 and done at +3 → done=0100 at +3, busy=0 at +4.
- All four requesting continuously, ready and done same-cycle → winners 0,1,2,3,0 in order, with valid at every other cycle.
- ISSUE backpressure: ready held low 5 cycles → valid, gnt and sel stable for all 5 cycles. done pulsed during ISSUE without ready is ignored, with no done output.
- Requester drops req in WAIT, then done arrives → done pulse still goes to that requester, and ptr advances past it.
- Reset in WAIT with gnt=0010 → next cycle gnt=0, valid=0, ptr=0, no done pulse. A later done input produces nothing.
- With RISCV_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4: done never arrives → timeout pulse on the 4th WAIT cycle, no done pulse, IDLE next cycle, ptr advanced.
